lsu_mem_access: RTL
===================

# lsu_mem_access

Data-memory access engine that consumes the one-hot load/store type produced by the decode-stage load/store decoder and carries out the access on a 32-bit word-addressed memory bus. It generates byte enables and lane-shifted store data, and splits word-crossing misaligned accesses into two bus beats. It assembles, aligns and sign/zero-extends load data, and returns one response per request. It sits between the execute/memory stage and the data-memory port.

## Interface

- ALLOW_MISALIGNED, 1: 1 = split word-crossing accesses into two beats; 0 = any non-naturally-aligned access returns an error without a bus access.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  engine can accept a request (high only in IDLE).
- req_we_i  in  1  1 = store, 0 = load.
- req_lstype_i  in  5  one-hot type: 10000 byte signed/sb, 01000 half signed/sh, 00100 word, 00010 lbu, 00001 lhu.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  illegal type or disallowed misalignment.
- mem_req_o  out  1  bus request, held until granted.
- mem_gnt_i  in  1  bus grant.
- mem_we_o  out  1  bus write.
- mem_addr_o  out  32  word-aligned address, bits [1:0] always 00.
- mem_be_o  out  4  byte enables, bit i = byte lane i.
- mem_wdata_o  out  32  lane-positioned store data.
- mem_rvalid_i  in  1  read data valid / write acknowledge.
- mem_rdata_i  in  32  read data.

## Operation

- FSM states: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
- IDLE: req_ready_o=1. On req_valid_i, register we, type, addr and wdata.
  - Illegal request goes to RESP with err=1. Illegal means: type not one-hot, or all-zero; store with 00010/00001; misaligned with ALLOW_MISALIGNED=0.
  - Otherwise go to BEAT0.
- Size n = 1/2/4 bytes. off = addr[1:0]. Split when off+n > 4.
- be0 = (2^n−1 << off)[3:0]. wdata0 = wdata << 8·off. Beat-0 address = {addr[31:2],00}.
- be1 = (2^n−1) >> (4−off). wdata1 = wdata >> 8·(4−off). Beat-1 address = beat-0 address + 4, wrapping 0xFFFFFFFC→0x00000000.
- BEAT0: mem_req_o=1 with beat-0 fields until mem_gnt_i, then go to WAIT0.
- WAIT0: on mem_rvalid_i, capture rdata0. Go to BEAT1 if split, else RESP.
- BEAT1 and WAIT1 behave the same with beat-1 fields; capture rdata1.
- Load result: {rdata1,rdata0} >> 8·off, keep low n bytes. Sign-extend for 10000/01000, zero-extend for 00010/00001. Word passes through.
- RESP: rsp_valid_o=1 for one cycle, then IDLE.
- No response backpressure.
- mem_rvalid_i outside WAIT0/WAIT1 is ignored.
- mem_rvalid_i in the same cycle as mem_gnt_i is not counted. The earliest valid rvalid is the cycle after the grant.

## Timing

- Reset: state IDLE. req_ready_o=1. All other outputs 0. Captured registers 0.
- All bus and response outputs are registered or decoded from state only. There is no combinational path from req_* to mem_* or rsp_*.
- Request accepted at edge T, aligned access, gnt and rvalid at the first opportunity:
  - mem_req_o high in cycle T+1.
  - rsp_valid_o high in cycle T+3.
- Split access, same conditions: rsp_valid_o in cycle T+5.
- Error: rsp_valid_o in cycle T+1. No mem_req_o.
- Each cycle of withheld gnt/rvalid adds one cycle.
- Back-to-back: req_ready_o rises the cycle after RESP. Throughput is one request per ≥4 cycles.
- Reset asserted mid-operation: immediate return to IDLE and all outputs 0. The outstanding bus beat is abandoned and no response is issued.

## Structure

- Package lsu_pkg holds:
  - localparams for the five LSType encodings;
  - the FSM state enum;
  - the size-from-type function.
- Sub-module lsu_lane_align (combinational) holds:
  - be0/be1 and wdata0/wdata1 generation;
  - load assembly and extension.
- lsu_mem_access keeps the FSM and capture registers.

## Test plan

- lw at 0x100, mem returns 0xDEADBEEF, gnt and rvalid immediate → mem_addr 0x100, be 1111, rsp_rdata 0xDEADBEEF at T+3, err 0.
- lb at 0x103 with 0x80xxxxxx in memory → be 1000, rsp 0xFFFFFF80. Same address with lbu → rsp 0x00000080.
- sh at 0x202, wdata 0x0000ABCD → be 1100, mem_wdata 0xABCD0000, rsp_rdata 0.
- lw at 0x0FE, ALLOW_MISALIGNED=1:
  - beat 0 at 0x0FC with be 1100, beat 1 at 0x100 with be 0011;
  - words 0x1122_3344 / 0x5566_7788 give rsp 0x77881122 at T+5.
- Store with type 00010, and type 01100 → rsp_err 1 at T+1, mem_req never asserted. Misaligned sh at 0x003 with ALLOW_MISALIGNED=0 → err.
- Grant withheld 3 cycles, then rst_n pulsed low during WAIT0 → outputs 0 immediately, no rsp_valid, and the next lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store access engine: one-hot access types,
// FSM states and the access-size helper.
package lsu_pkg;

   localparam logic [4:0] LS_B  = 5'b10000;
   localparam logic [4:0] LS_H  = 5'b01000;
   localparam logic [4:0] LS_W  = 5'b00100;
   localparam logic [4:0] LS_BU = 5'b00010;
   localparam logic [4:0] LS_HU = 5'b00001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BEAT0,
      S_WAIT0,
      S_BEAT1,
      S_WAIT1,
      S_RESP
   } state_e;

   // Access size in bytes; 0 marks an encoding that is not a legal type.
   function automatic logic [2:0] ls_size(input logic [4:0] lstype);
      logic [2:0] n;
      case (lstype)
         LS_B, LS_BU: n = 3'd1;
         LS_H, LS_HU: n = 3'd2;
         LS_W:        n = 3'd4;
         default:     n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Request/response and data-memory bus signals of the access engine.
// The engine uses the slave modport; the requester/memory side uses master.
interface lsu_mem_access_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [4:0]  req_lstype_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_lstype_i, req_addr_i, req_wdata_i,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_lstype_i, req_addr_i, req_wdata_i,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables and store data for both beats,
// plus assembly and sign/zero extension of load data.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [4:0]  lstype_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata0_i,
   input  logic [31:0] rdata1_i,
   output logic [3:0]  be0_o,
   output logic [3:0]  be1_o,
   output logic [31:0] wdata0_o,
   output logic [31:0] wdata1_o,
   output logic [31:0] rdata_o,
   output logic        split_o
);

   logic [2:0]  size;
   logic [7:0]  mask;
   logic [63:0] wshift;
   logic [31:0] rlow;

   always_comb begin
      size    = ls_size(lstype_i);
      // Upper nibble of the 8-lane mask is exactly the beat-1 enables.
      mask    = ((8'd1 << size) - 8'd1) << off_i;
      be0_o   = mask[3:0];
      be1_o   = mask[7:4];
      split_o = ({2'b00, off_i} + {1'b0, size}) > 4'd4;

      wshift   = {32'h0, wdata_i} << {off_i, 3'b000};
      wdata0_o = wshift[31:0];
      wdata1_o = wshift[63:32];

      rlow = 32'({rdata1_i, rdata0_i} >> {off_i, 3'b000});
      case (lstype_i)
         LS_B:    rdata_o = {{24{rlow[7]}}, rlow[7:0]};
         LS_H:    rdata_o = {{16{rlow[15]}}, rlow[15:0]};
         LS_BU:   rdata_o = {24'h0, rlow[7:0]};
         LS_HU:   rdata_o = {16'h0, rlow[15:0]};
         LS_W:    rdata_o = rlow;
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_access.sv
// Data-memory access engine: one request at a time, optionally split into two
// bus beats, with one response per request.
module lsu_mem_access
   import lsu_pkg::*;
#(
   parameter logic ALLOW_MISALIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   lsu_mem_access_if.slave  bus
);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [4:0]  type_q, type_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic [3:0]  be0, be1;
   logic [31:0] wdata0, wdata1, rdata_ext, word_addr;
   logic        split;
   logic [2:0]  req_size;
   logic [1:0]  align_mask;
   logic        illegal;

   lsu_lane_align u_align (
      .lstype_i (type_q),
      .off_i    (addr_q[1:0]),
      .wdata_i  (wdata_q),
      .rdata0_i (rdata0_q),
      .rdata1_i (rdata1_q),
      .be0_o    (be0),
      .be1_o    (be1),
      .wdata0_o (wdata0),
      .wdata1_o (wdata1),
      .rdata_o  (rdata_ext),
      .split_o  (split)
   );

   assign word_addr = {addr_q[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         type_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         type_q   <= type_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Legality is judged on the raw request; ls_size is 0 for non-one-hot types.
   always_comb begin
      req_size   = ls_size(bus.req_lstype_i);
      align_mask = (req_size == 3'd4) ? 2'b11 : (req_size == 3'd2) ? 2'b01 : 2'b00;
      illegal    = (req_size == 3'd0)
                 || (bus.req_we_i && (bus.req_lstype_i == LS_BU || bus.req_lstype_i == LS_HU))
                 || (!ALLOW_MISALIGNED && ((bus.req_addr_i[1:0] & align_mask) != 2'b00));
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      type_d   = type_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid_i) begin
               we_d     = bus.req_we_i;
               type_d   = bus.req_lstype_i;
               addr_d   = bus.req_addr_i;
               wdata_d  = bus.req_wdata_i;
               err_d    = illegal;
               rdata0_d = '0;
               rdata1_d = '0;
               state_d  = illegal ? S_RESP : S_BEAT0;
            end
         end
         S_BEAT0: if (bus.mem_gnt_i) state_d = S_WAIT0;
         S_WAIT0: begin
            if (bus.mem_rvalid_i) begin
               rdata0_d = bus.mem_rdata_i;
               state_d  = split ? S_BEAT1 : S_RESP;
            end
         end
         S_BEAT1: if (bus.mem_gnt_i) state_d = S_WAIT1;
         S_WAIT1: begin
            if (bus.mem_rvalid_i) begin
               rdata1_d = bus.mem_rdata_i;
               state_d  = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready_o = (state_q == S_IDLE);
      bus.rsp_valid_o = 1'b0;
      bus.rsp_rdata_o = '0;
      bus.rsp_err_o   = 1'b0;
      bus.mem_req_o   = 1'b0;
      bus.mem_we_o    = 1'b0;
      bus.mem_addr_o  = '0;
      bus.mem_be_o    = '0;
      bus.mem_wdata_o = '0;
      case (state_q)
         S_BEAT0: begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = we_q;
            bus.mem_addr_o  = word_addr;
            bus.mem_be_o    = be0;
            bus.mem_wdata_o = we_q ? wdata0 : '0;
         end
         S_BEAT1: begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = we_q;
            bus.mem_addr_o  = word_addr + 32'd4;
            bus.mem_be_o    = be1;
            bus.mem_wdata_o = we_q ? wdata1 : '0;
         end
         S_RESP: begin
            bus.rsp_valid_o = 1'b1;
            bus.rsp_err_o   = err_q;
            bus.rsp_rdata_o = (err_q || we_q) ? '0 : rdata_ext;
         end
         default: ;
      endcase
   end

endmodule
